// File: rtl/bin_descrambler8_if.sv
// Bin stream bundle for bin_descrambler8: natural-order input bins plus keys in,
// de-permuted bins out. master = frame source/sink side, slave = descrambler.
interface bin_descrambler8_if #(parameter int DW = 16);
  logic          di_en;
  logic [DW-1:0] di_re;
  logic [DW-1:0] di_im;
  logic [23:0]   key_lo;
  logic [23:0]   key_hi;
  logic          do_en;
  logic [DW-1:0] do_re;
  logic [DW-1:0] do_im;
  logic [5:0]    do_count;
  logic          key_err;

  modport master (output di_en, di_re, di_im, key_lo, key_hi,
                  input  do_en, do_re, do_im, do_count, key_err);
  modport slave  (input  di_en, di_re, di_im, key_lo, key_hi,
                  output do_en, do_re, do_im, do_count, key_err);
endinterface

// File: rtl/bin_descrambler8.sv
// Undoes the 8-bin permutation on bins 0-7 / 56-63 of 64-bin frames via a ping-pong RAM.
// Optional key validation (identity fallback + key_err) under BIN_DESCRAMBLER_KEY_CHECK_EN.
module bin_descrambler8 #(
  parameter int DW = 16
) (
  input  logic              clock,
  input  logic              reset,
  bin_descrambler8_if.slave io
);
  localparam logic [0:0]  S_IDLE    = 1'b0;
  localparam logic [0:0]  S_READ    = 1'b1;
  localparam logic [23:0] KEY_IDENT = 24'o76543210;

  logic [2*DW-1:0] bank_mem [128];

  logic [5:0]    wr_cnt_q, wr_cnt_d;
  logic          wr_bank_q, wr_bank_d;
  logic [5:0]    rd_cnt_q, rd_cnt_d;
  logic          rd_bank_q, rd_bank_d;
  logic [0:0]    state_q, state_d;
  logic [23:0]   key_lo_q, key_lo_d, key_hi_q, key_hi_d;
  logic [23:0]   lo_map, hi_map;
  logic          do_en_q, do_en_d;
  logic [DW-1:0] do_re_q, do_re_d, do_im_q, do_im_d;
  logic [5:0]    do_count_q, do_count_d;
  logic          key_err_q, key_err_d;
  logic          latch, wr_last;
  logic [5:0]    wr_addr;

  // The _d key is already the new key on the bin-0 cycle, so bin 0 maps with it.
  always_comb begin
    latch    = io.di_en && (wr_cnt_q == 6'd0);
    wr_last  = io.di_en && (wr_cnt_q == 6'd63);
    key_lo_d = latch ? io.key_lo : key_lo_q;
    key_hi_d = latch ? io.key_hi : key_hi_q;
  end

`ifdef BIN_DESCRAMBLER_KEY_CHECK_EN
  function automatic logic is_perm(input logic [23:0] k);
    logic [7:0] seen;
    seen = '0;
    for (int i = 0; i < 8; i++) seen[k[3*i +: 3]] = 1'b1;
    return &seen;
  endfunction

  logic lo_bad, hi_bad;
  always_comb begin
    lo_bad = (key_lo_d != '0) && !is_perm(key_lo_d);
    hi_bad = (key_hi_d != '0) && !is_perm(key_hi_d);
  end
  assign lo_map    = (key_lo_d == '0 || lo_bad) ? KEY_IDENT : key_lo_d;
  assign hi_map    = (key_hi_d == '0 || hi_bad) ? KEY_IDENT : key_hi_d;
  assign key_err_d = latch ? (lo_bad | hi_bad) : key_err_q;
`else
  assign lo_map    = (key_lo_d == '0) ? KEY_IDENT : key_lo_d;
  assign hi_map    = (key_hi_d == '0) ? KEY_IDENT : key_hi_d;
  assign key_err_d = 1'b0;
`endif

  // Only the edge groups are permuted; the group base is just wr_cnt[5:3].
  always_comb begin
    case (wr_cnt_q[5:3])
      3'd0:    wr_addr = {3'd0, lo_map[3*wr_cnt_q[2:0] +: 3]};
      3'd7:    wr_addr = {3'd7, hi_map[3*wr_cnt_q[2:0] +: 3]};
      default: wr_addr = wr_cnt_q;
    endcase
  end

  always_comb begin
    wr_cnt_d   = io.di_en ? wr_cnt_q + 6'd1 : wr_cnt_q;
    wr_bank_d  = wr_last ? ~wr_bank_q : wr_bank_q;
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    rd_bank_d  = rd_bank_q;
    do_en_d    = (state_q == S_READ);
    do_re_d    = do_re_q;
    do_im_d    = do_im_q;
    do_count_d = do_count_q;
    // A frame completing on the last read beat restarts read-out without a gap.
    if (wr_last) begin
      state_d   = S_READ;
      rd_cnt_d  = 6'd0;
      rd_bank_d = wr_bank_q;
    end else if (state_q == S_READ) begin
      rd_cnt_d = rd_cnt_q + 6'd1;
      if (rd_cnt_q == 6'd63) state_d = S_IDLE;
    end
    if (state_q == S_READ) begin
      {do_re_d, do_im_d} = bank_mem[{rd_bank_q, rd_cnt_q}];
      do_count_d         = rd_cnt_q;
    end
  end

  always_ff @(posedge clock) begin
    if (io.di_en && !reset) bank_mem[{wr_bank_q, wr_addr}] <= {io.di_re, io.di_im};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_cnt_q   <= '0;
      wr_bank_q  <= 1'b0;
      rd_cnt_q   <= '0;
      rd_bank_q  <= 1'b0;
      state_q    <= S_IDLE;
      key_lo_q   <= '0;
      key_hi_q   <= '0;
      do_en_q    <= 1'b0;
      do_re_q    <= '0;
      do_im_q    <= '0;
      do_count_q <= '0;
      key_err_q  <= 1'b0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      wr_bank_q  <= wr_bank_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_bank_q  <= rd_bank_d;
      state_q    <= state_d;
      key_lo_q   <= key_lo_d;
      key_hi_q   <= key_hi_d;
      do_en_q    <= do_en_d;
      do_re_q    <= do_re_d;
      do_im_q    <= do_im_d;
      do_count_q <= do_count_d;
      key_err_q  <= key_err_d;
    end
  end

  assign io.do_en    = do_en_q;
  assign io.do_re    = do_re_q;
  assign io.do_im    = do_im_q;
  assign io.do_count = do_count_q;
  assign io.key_err  = key_err_q;
endmodule

// File: tb/tb_bin_descrambler8.sv
// Directed frame sequence with random data/keys; a RAM-level model (two 64-entry banks)
// predicts every output bin and the cycle it must appear on.
module tb_bin_descrambler8;
  localparam int DW = 16;
  localparam logic [23:0] IDENT = 24'o76543210;

  typedef struct {
    int             cyc;
    logic [5:0]     cnt;
    logic [2*DW-1:0] d;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   mon_on = 1'b0;
  bit   want;
  bit   exp_kerr = 1'b0;
  int   wb = 0;
  logic [2*DW-1:0] last_d;
  logic [2*DW-1:0] mbank [2][64];
  exp_t exp_q[$];
  exp_t me;

  bin_descrambler8_if #(.DW(DW)) io();
  bin_descrambler8 #(.DW(DW)) dut (.clock(clock), .reset(reset), .io(io));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Effective key as seen by the spec: zero means identity; invalid means identity when checked.
  function automatic logic [23:0] eff(input logic [23:0] k, output bit bad);
    bad = 1'b0;
    if (k == '0) return IDENT;
`ifdef BIN_DESCRAMBLER_KEY_CHECK_EN
    begin
      logic [7:0] seen;
      seen = '0;
      for (int i = 0; i < 8; i++) seen[k[3*i +: 3]] = 1'b1;
      if (seen != 8'hFF) begin
        bad = 1'b1;
        return IDENT;
      end
    end
`endif
    return k;
  endfunction

  function automatic logic [23:0] rand_perm();
    int a[8];
    int j, t;
    logic [23:0] k;
    for (int i = 0; i < 8; i++) a[i] = i;
    for (int i = 7; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = a[i]; a[i] = a[j]; a[j] = t;
    end
    for (int i = 0; i < 8; i++) k[3*i +: 3] = 3'(a[i]);
    return k;
  endfunction

  always @(negedge clock) if (mon_on) begin
    want = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    chk("do_en", io.do_en, want);
    if (want) begin
      me = exp_q.pop_front();
      chk("do_count", io.do_count, me.cnt);
      chk("do_data", {io.do_re, io.do_im}, me.d);
      last_d = me.d;
    end else if (!io.do_en) begin
      chk("hold_data", {io.do_re, io.do_im}, last_d);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      io.di_en = 1'b0;
    end
  endtask

  task automatic do_reset();
    int r;
    io.di_en = 1'b0;
    reset = 1'b1;
    r = cyc;
    @(posedge clock); #1;
    reset = 1'b0;
    while (exp_q.size() > 0 && exp_q[$].cyc > r) void'(exp_q.pop_back());
    chk("rst_do_en", io.do_en, 1'b0);
    chk("rst_do_count", io.do_count, 6'd0);
    chk("rst_key_err", io.key_err, 1'b0);
    chk("rst_do_data", {io.do_re, io.do_im}, '0);
    last_d = '0;
    wb = 0;
    exp_kerr = 1'b0;
  endtask

  // mode 0: (k,-k); mode 1: (i,i); else random. gaps inserts an idle cycle before each bin.
  task automatic drive_frame(input logic [23:0] klo, input logic [23:0] khi,
                             input int mode, input bit gaps, input int abort_at);
    logic [23:0] elo, ehi;
    bit blo, bhi;
    logic [DW-1:0] re, im;
    int addr;
    for (int i = 0; i < 64; i++) begin
      if (gaps && i > 0) begin
        @(posedge clock); #1;
        io.di_en = 1'b0;
      end
      @(posedge clock); #1;
      if (i == 1) chk("key_err", io.key_err, exp_kerr);
      if (i == abort_at) begin
        do_reset();
        return;
      end
      case (mode)
        0:       begin re = DW'(i); im = DW'(-i); end
        1:       begin re = DW'(i); im = DW'(i); end
        default: begin re = DW'($urandom); im = DW'($urandom); end
      endcase
      io.di_en  = 1'b1;
      io.di_re  = re;
      io.di_im  = im;
      io.key_lo = (i < 30) ? klo : 24'($urandom);
      io.key_hi = (i < 30) ? khi : 24'($urandom);
      if (i == 0) begin
        elo = eff(klo, blo);
        ehi = eff(khi, bhi);
        exp_kerr = blo | bhi;
      end
      if (i < 8)        addr = int'(elo[3*i +: 3]);
      else if (i >= 56) addr = 56 + int'(ehi[3*(i-56) +: 3]);
      else              addr = i;
      mbank[wb][addr] = {re, im};
      if (i == 63) begin
        for (int k = 0; k < 64; k++) exp_q.push_back('{cyc + 2 + k, 6'(k), mbank[wb][k]});
        wb ^= 1;
      end
    end
  endtask

  initial begin
    io.di_en = 1'b0; io.di_re = '0; io.di_im = '0;
    io.key_lo = '0;  io.key_hi = '0;
    @(posedge clock); #1;
    do_reset();
    mon_on = 1'b1;

    drive_frame(24'd0, 24'd0, 0, 1'b0, -1);
    drive_frame(24'o01234567, 24'd0, 1, 1'b0, -1);
    idle(70);
    drive_frame(rand_perm(), rand_perm(), 2, 1'b0, -1);
    drive_frame(rand_perm(), rand_perm(), 2, 1'b0, -1);
    drive_frame(24'o00000001, rand_perm(), 2, 1'b0, -1);
    drive_frame(rand_perm(), 24'd0, 2, 1'b0, -1);
    drive_frame(rand_perm(), rand_perm(), 2, 1'b0, -1);
    drive_frame(rand_perm(), rand_perm(), 2, 1'b0, 40);
    drive_frame(rand_perm(), rand_perm(), 2, 1'b0, -1);
    drive_frame(rand_perm(), rand_perm(), 2, 1'b1, -1);
    idle(80);
    chk("drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
